// File: rtl/bus_write_arbiter_if.sv
// Signal bundle between requesters/downstream (master side) and bus_write_arbiter (slave side).
interface bus_write_arbiter_if #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned DW    = 16
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    gnt;
    logic                bus_valid;
    logic [DW-1:0]       bus_data;
    logic                bus_last;
    logic [1:0]          bus_owner;
    logic                bus_ready;
    logic                locked;
    logic                tmo_err;

    modport master (
        output req, req_data, req_last, bus_ready,
        input  gnt, bus_valid, bus_data, bus_last, bus_owner, locked, tmo_err
    );

    modport slave (
        input  req, req_data, req_last, bus_ready,
        output gnt, bus_valid, bus_data, bus_last, bus_owner, locked, tmo_err
    );
endinterface

// File: rtl/bus_write_arbiter.sv
// Round-robin, burst-locking write arbiter for three requesters onto one registered bus,
// with a lock watchdog that frees the bus when the owner goes idle mid-burst.
module bus_write_arbiter #(
    parameter int unsigned N_REQ    = 3,
    parameter int unsigned DW       = 16,
    parameter int unsigned LOCK_TMO = 15
) (
    input  logic               clk,
    input  logic               rst,
    bus_write_arbiter_if.slave io
);
    localparam int unsigned OW = 2;
    localparam int unsigned CW = 8;

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;
    logic          bus_valid_q, bus_valid_d;
    logic [DW-1:0] bus_data_q, bus_data_d;
    logic          bus_last_q, bus_last_d;
    logic [OW-1:0] bus_owner_q, bus_owner_d;

    logic          load_c;
    logic          win_vld_c;
    logic [OW-1:0] win_idx_c;
    logic          gnt_vld_c;
    logic [OW-1:0] gnt_idx_c;
    logic [DW-1:0] beat_data_c [N_REQ];

    function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] idx);
        return (idx == OW'(N_REQ - 1)) ? '0 : idx + OW'(1);
    endfunction

    assign load_c = !bus_valid_q || io.bus_ready;

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            beat_data_c[i] = io.req_data[i*DW +: DW];
        end
    end

    // First asserted request at or after rr_ptr, wrapping.
    always_comb begin
        logic [OW-1:0] idx;
        win_vld_c = 1'b0;
        win_idx_c = rr_ptr_q;
        idx       = rr_ptr_q;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!win_vld_c && io.req[idx]) begin
                win_vld_c = 1'b1;
                win_idx_c = idx;
            end
            idx = next_idx(idx);
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = 1'b0;
        gnt_vld_c   = 1'b0;
        gnt_idx_c   = win_idx_c;
        bus_valid_d = bus_valid_q;
        bus_data_d  = bus_data_q;
        bus_last_d  = bus_last_q;
        bus_owner_d = bus_owner_q;

        unique case (state_q)
            ST_UNLOCKED: begin
                tmo_cnt_d = '0;
                if (load_c && win_vld_c) begin
                    gnt_vld_c = 1'b1;
                    if (io.req_last[win_idx_c]) begin
                        rr_ptr_d = next_idx(win_idx_c);
                    end else begin
                        state_d = ST_LOCKED;
                        owner_d = win_idx_c;
                    end
                end
            end
            ST_LOCKED: begin
                gnt_idx_c = owner_q;
                // Expiry takes priority even if the owner's request returns this cycle.
                if (tmo_cnt_q == CW'(LOCK_TMO)) begin
                    state_d   = ST_UNLOCKED;
                    rr_ptr_d  = next_idx(owner_q);
                    tmo_err_d = 1'b1;
                    tmo_cnt_d = '0;
                end else if (io.req[owner_q]) begin
                    if (load_c) begin
                        gnt_vld_c = 1'b1;
                        tmo_cnt_d = '0;
                        if (io.req_last[owner_q]) begin
                            state_d  = ST_UNLOCKED;
                            rr_ptr_d = next_idx(owner_q);
                        end
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CW'(1);
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        if (rst) begin
            gnt_vld_c = 1'b0;
        end

        if (load_c) begin
            bus_valid_d = gnt_vld_c;
            if (gnt_vld_c) begin
                bus_data_d  = beat_data_c[gnt_idx_c];
                bus_last_d  = io.req_last[gnt_idx_c];
                bus_owner_d = gnt_idx_c;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_UNLOCKED;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            bus_last_q  <= 1'b0;
            bus_owner_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            bus_last_q  <= bus_last_d;
            bus_owner_q <= bus_owner_d;
        end
    end

    assign io.gnt       = gnt_vld_c ? (N_REQ'(1) << gnt_idx_c) : '0;
    assign io.bus_valid = bus_valid_q;
    assign io.bus_data  = bus_data_q;
    assign io.bus_last  = bus_last_q;
    assign io.bus_owner = bus_owner_q;
    assign io.locked    = (state_q == ST_LOCKED);
    assign io.tmo_err   = tmo_err_q;
endmodule

// File: tb/tb_bus_write_arbiter.sv
// Bench for bus_write_arbiter: directed scenarios plus random requester agents, all checked
// cycle by cycle against a behavioural model of the arbitration rules.
module tb_bus_write_arbiter;
    localparam int unsigned N_REQ    = 3;
    localparam int unsigned DW       = 16;
    localparam int unsigned LOCK_TMO = 15;

    logic clk;
    logic rst;

    bus_write_arbiter_if #(.N_REQ(N_REQ), .DW(DW)) bif ();

    bus_write_arbiter #(.N_REQ(N_REQ), .DW(DW), .LOCK_TMO(LOCK_TMO)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Model state: lock, owner, pointer, idle count, and the output register contents.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    bit          m_vld;
    logic [15:0] m_data;
    bit          m_last;
    int          m_own;
    bit          m_err;

    logic [2:0]  last_gnt;
    logic        last_tmo;
    logic        last_locked;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_vld = 1'b0; m_data = '0; m_last = 1'b0; m_own = 0; m_err = 1'b0;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int          w;
        bit          load;
        bit          expire;
        bit          owner_req;
        logic [15:0] w_data;
        bit          w_last;
        @(negedge clk);
        load      = !m_vld || bif.bus_ready;
        w         = -1;
        expire    = 1'b0;
        owner_req = bif.req[m_owner];
        if (m_locked) begin
            if (m_cnt == int'(LOCK_TMO)) expire = 1'b1;
            else if (load && owner_req) w = m_owner;
        end else if (load) begin
            for (int k = 0; k < int'(N_REQ); k++) begin
                int c;
                c = (m_ptr + k) % int'(N_REQ);
                if (w < 0 && bif.req[c]) w = c;
            end
        end
        w_data = '0;
        w_last = 1'b0;
        if (w >= 0) begin
            w_data = bif.req_data[w*DW +: DW];
            w_last = bif.req_last[w];
        end
        last_gnt    = bif.gnt;
        last_tmo    = bif.tmo_err;
        last_locked = bif.locked;
        check("gnt",       32'(bif.gnt),       (w >= 0) ? (32'(1) << w) : 32'(0));
        check("bus_valid", 32'(bif.bus_valid), 32'(m_vld));
        check("bus_data",  32'(bif.bus_data),  32'(m_data));
        check("bus_last",  32'(bif.bus_last),  32'(m_last));
        check("bus_owner", 32'(bif.bus_owner), 32'(m_own));
        check("locked",    32'(bif.locked),    32'(m_locked));
        check("tmo_err",   32'(bif.tmo_err),   32'(m_err));
        @(posedge clk);
        m_err = expire;
        if (load) begin
            m_vld = (w >= 0);
            if (w >= 0) begin
                m_data = w_data; m_last = w_last; m_own = w;
            end
        end
        if (expire) begin
            m_locked = 1'b0; m_ptr = (m_owner + 1) % int'(N_REQ); m_cnt = 0;
        end else if (w >= 0) begin
            m_cnt = 0;
            if (w_last) begin
                m_locked = 1'b0; m_ptr = (w + 1) % int'(N_REQ);
            end else begin
                m_locked = 1'b1; m_owner = w;
            end
        end else if (m_locked && !owner_req) begin
            m_cnt++;
        end else if (!m_locked) begin
            m_cnt = 0;
        end
        #1;
    endtask

    // Called just after a rising edge; reset takes effect without waiting for a clock.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_bus_valid", 32'(bif.bus_valid), 32'(0));
        check("rst_locked",    32'(bif.locked),    32'(0));
        check("rst_gnt",       32'(bif.gnt),       32'(0));
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [15:0] d, input bit l);
        bif.req[i]              = v;
        bif.req_data[i*DW +: DW] = d;
        bif.req_last[i]         = l;
    endtask

    int rem   [N_REQ];
    int stall [N_REQ];
    int found;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bif.req = '0; bif.req_data = '0; bif.req_last = '0; bif.bus_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_bus_data",  32'(bif.bus_data),  32'(0));
        check("reset_bus_owner", 32'(bif.bus_owner), 32'(0));
        check("reset_tmo_err",   32'(bif.tmo_err),   32'(0));
        rst = 1'b0;

        // Single requester, single beat.
        bif.bus_ready = 1'b1;
        set_req(0, 1'b1, 16'hdead, 1'b1);
        cycle();
        check("single_gnt", 32'(last_gnt), 32'(1));
        bif.req = '0;
        check("single_valid", 32'(bif.bus_valid), 32'(1));
        check("single_data",  32'(bif.bus_data),  32'(16'hdead));
        check("single_owner", 32'(bif.bus_owner), 32'(0));
        check("single_last",  32'(bif.bus_last),  32'(1));
        set_req(0, 1'b1, 16'h0001, 1'b1);
        set_req(1, 1'b1, 16'h0002, 1'b1);
        cycle();
        check("single_ptr1", 32'(last_gnt), 32'(2));
        bif.req = '0;
        cycle();

        // Fairness from a fresh pointer.
        do_reset();
        for (int i = 0; i < int'(N_REQ); i++) set_req(i, 1'b1, 16'(16'h1000 + i), 1'b1);
        for (int j = 0; j < 6; j++) begin
            cycle();
            check("fair_gnt",   32'(last_gnt),      32'(1) << (j % 3));
            check("fair_valid", 32'(bif.bus_valid), 32'(1));
            check("fair_owner", 32'(bif.bus_owner), 32'(j % 3));
        end
        bif.req = '0;
        cycle();

        // Burst lock for requester 1 against competing requests.
        set_req(0, 1'b1, 16'h0aaa, 1'b1);
        cycle();
        bif.req = '0;
        set_req(0, 1'b1, 16'h0aaa, 1'b1);
        set_req(2, 1'b1, 16'h2222, 1'b1);
        for (int j = 0; j < 4; j++) begin
            logic [15:0] beats [3];
            beats[0] = 16'hbeef; beats[1] = 16'hface; beats[2] = 16'hcafe;
            if (j < 3) set_req(1, 1'b1, beats[j], (j == 2));
            else       bif.req[1] = 1'b0;
            cycle();
            if (j < 3) begin
                check("lock_gnt",   32'(last_gnt),      32'(2));
                check("lock_data",  32'(bif.bus_data),  32'(beats[j]));
                check("lock_owner", 32'(bif.bus_owner), 32'(1));
            end else begin
                check("lock_next_gnt", 32'(last_gnt), 32'(4));
            end
        end
        bif.req = '0;
        cycle();

        // Backpressure: held beat, no grants, reload on the ready cycle.
        set_req(0, 1'b1, 16'h1234, 1'b1);
        cycle();
        bif.req = '0;
        bif.bus_ready = 1'b0;
        set_req(1, 1'b1, 16'h5678, 1'b1);
        for (int j = 0; j < 4; j++) begin
            cycle();
            check("bp_gnt",  32'(last_gnt),     32'(0));
            check("bp_data", 32'(bif.bus_data), 32'(16'h1234));
        end
        bif.bus_ready = 1'b1;
        cycle();
        check("bp_reload_gnt", 32'(last_gnt),     32'(2));
        check("bp_new_data",   32'(bif.bus_data), 32'(16'h5678));
        bif.req = '0;

        // Watchdog: owner goes idle mid-burst while requester 1 waits.
        set_req(0, 1'b1, 16'haaaa, 1'b0);
        cycle();
        check("wd_first_gnt", 32'(last_gnt), 32'(1));
        bif.req[0] = 1'b0;
        set_req(1, 1'b1, 16'h5a5a, 1'b1);
        found = -1;
        for (int k = 1; k <= 40; k++) begin
            cycle();
            if (last_tmo === 1'b1) begin
                found = k;
                check("wd_delay",  32'(k),           32'(LOCK_TMO + 2));
                check("wd_gnt",    32'(last_gnt),    32'(2));
                check("wd_locked", 32'(last_locked), 32'(0));
                bif.req = '0;
                break;
            end
        end
        if (found < 0) check("wd_seen", 32'(0), 32'(1));
        cycle();
        check("wd_pulse_len", 32'(last_tmo), 32'(0));

        // Reset in the middle of a locked burst.
        set_req(0, 1'b1, 16'h0bad, 1'b0);
        cycle();
        bif.req = '0;
        check("mid_locked", 32'(bif.locked),    32'(1));
        check("mid_valid",  32'(bif.bus_valid), 32'(1));
        do_reset();
        set_req(1, 1'b1, 16'h1111, 1'b1);
        set_req(2, 1'b1, 16'h2222, 1'b1);
        cycle();
        check("post_rst_gnt1", 32'(last_gnt), 32'(2));
        bif.req[1] = 1'b0;
        cycle();
        check("post_rst_gnt2", 32'(last_gnt), 32'(4));
        bif.req = '0;

        // Random agents with bursts, gaps, occasional long stalls and random backpressure.
        for (int i = 0; i < int'(N_REQ); i++) begin rem[i] = 0; stall[i] = 0; end
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (bif.req[i] && last_gnt[i]) begin
                    bif.req[i] = 1'b0;
                    if (rem[i] > 0) rem[i]--;
                end
                if (!bif.req[i]) begin
                    if (stall[i] > 0) stall[i]--;
                    else if (rem[i] == 0) begin
                        if ($urandom_range(0, 3) == 0) rem[i] = int'($urandom_range(1, 4));
                    end else if ($urandom_range(0, 299) == 0) stall[i] = int'($urandom_range(10, 25));
                    else if ($urandom_range(0, 7) != 0) set_req(i, 1'b1, 16'($urandom), (rem[i] == 1));
                end
            end
            bif.bus_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
